// File: rtl/instruction_pkg.sv
// rtl/instruction_pkg.sv - opcode encoding and FSM state types shared by basic_block_wide.
package instruction;

  localparam int INSTRUCTION_TYPE_WIDTH = 3;
  localparam int INSTRUCTION_DATA_WIDTH = 13;

  typedef enum logic [INSTRUCTION_TYPE_WIDTH-1:0] {
    ACCEPT         = 3'd0,
    SPLIT          = 3'd1,
    MATCH          = 3'd2,
    JMP            = 3'd3,
    NOT_MATCH      = 3'd4,
    MATCH_ANY      = 3'd5,
    ACCEPT_PARTIAL = 3'd6
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_DATA,
    ST_EXEC,
    ST_OUT_A,
    ST_OUT_B
  } state_t;

endpackage

// File: rtl/basic_block_wide.sv
// rtl/basic_block_wide.sv - single-pc instruction executor: fetch, decode, emit successor pcs.
// Optional one-entry instruction buffer enabled by BASIC_BLOCK_INSTR_CACHE_EN.
module basic_block_wide
  import instruction::*;
#(
  parameter int PC_WIDTH          = 8,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int CC_ID_BITS        = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]    current_characters,
  input  logic                                          input_pc_valid,
  input  logic [PC_WIDTH-1:0]                           input_pc,
  input  logic [CC_ID_BITS-1:0]                         input_cc_id,
  output logic                                          input_pc_ready,
  output logic                                          memory_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]                  memory_addr,
  input  logic                                          memory_ready,
  input  logic [MEMORY_WIDTH-1:0]                       memory_data,
  output logic                                          output_pc_valid,
  output logic [PC_WIDTH-1:0]                           output_pc,
  output logic [CC_ID_BITS-1:0]                         output_cc_id,
  output logic                                          output_pc_is_directed_to_current,
  input  logic                                          output_pc_ready,
  output logic                                          accepts
);

  state_t                         state_q;
  logic [PC_WIDTH-1:0]            pc_q;
  logic [CC_ID_BITS-1:0]          cc_q;
  logic [MEMORY_WIDTH-1:0]        instr_q;
  logic                           split_q;
  logic                           in_ready_q;
  logic                           mem_valid_q;
  logic [MEMORY_ADDR_WIDTH-1:0]   mem_addr_q;
  logic                           out_valid_q;
  logic [PC_WIDTH-1:0]            out_pc_q;
  logic [CC_ID_BITS-1:0]          out_cc_q;
  logic                           out_dir_q;

  logic [INSTRUCTION_TYPE_WIDTH-1:0] opcode;
  logic [CHARACTER_WIDTH-1:0]     sel_char;
  logic [CHARACTER_WIDTH-1:0]     cmp_data;
  logic [PC_WIDTH-1:0]            target_pc;
  logic [PC_WIDTH-1:0]            pc_inc;
  logic [CC_ID_BITS-1:0]          cc_inc;
  logic                           char_eq;
  logic                           match_taken;
  logic                           cache_hit;
  logic                           unused_instr;

  assign opcode       = instr_q[MEMORY_WIDTH-1 -: INSTRUCTION_TYPE_WIDTH];
  assign cmp_data     = instr_q[CHARACTER_WIDTH-1:0];
  assign target_pc    = instr_q[PC_WIDTH-1:0];
  assign pc_inc       = pc_q + PC_WIDTH'(1);
  assign cc_inc       = cc_q + CC_ID_BITS'(1);
  assign char_eq      = (sel_char == cmp_data);
  assign unused_instr = ^instr_q;

  always_comb begin
    sel_char = '0;
    for (int k = 0; k < 2**CC_ID_BITS; k++) begin
      if (cc_q == k[CC_ID_BITS-1:0]) begin
        sel_char = current_characters[k*CHARACTER_WIDTH +: CHARACTER_WIDTH];
      end
    end
  end

  always_comb begin
    match_taken = 1'b0;
    case (opcode)
      MATCH:     match_taken = char_eq;
      NOT_MATCH: match_taken = !char_eq;
      MATCH_ANY: match_taken = 1'b1;
      default:   match_taken = 1'b0;
    endcase
  end

  // The accept pulse must coincide with the EXEC cycle itself, so it is decoded, not registered.
  assign accepts = (state_q == ST_EXEC) &&
                   ((opcode == ACCEPT && sel_char == '0) || opcode == ACCEPT_PARTIAL);

`ifdef BASIC_BLOCK_INSTR_CACHE_EN
  logic [PC_WIDTH-1:0] tag_q;
  logic                tag_valid_q;

  // instr_q only changes on a real fetch, so it doubles as the buffered instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
    end else if (state_q == ST_WAIT_DATA) begin
      tag_q       <= pc_q;
      tag_valid_q <= 1'b1;
    end
  end

  assign cache_hit = tag_valid_q && (tag_q == input_pc);
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      cc_q        <= '0;
      instr_q     <= '0;
      split_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_cc_q    <= '0;
      out_dir_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (input_pc_valid) begin
            pc_q       <= input_pc;
            cc_q       <= input_cc_id;
            in_ready_q <= 1'b0;
            if (cache_hit) begin
              state_q <= ST_EXEC;
            end else begin
              state_q     <= ST_FETCH;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= MEMORY_ADDR_WIDTH'(input_pc);
            end
          end
        end
        ST_FETCH: begin
          if (memory_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          instr_q <= memory_data;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          split_q <= (opcode == SPLIT);
          case (opcode)
            JMP: begin
              out_pc_q    <= target_pc;
              out_cc_q    <= cc_q;
              out_dir_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= ST_OUT_A;
            end
            SPLIT: begin
              out_pc_q    <= pc_inc;
              out_cc_q    <= cc_q;
              out_dir_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= ST_OUT_A;
            end
            MATCH, NOT_MATCH, MATCH_ANY: begin
              if (match_taken) begin
                out_pc_q    <= pc_inc;
                out_cc_q    <= cc_inc;
                out_dir_q   <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= ST_OUT_A;
              end else begin
                in_ready_q <= 1'b1;
                state_q    <= ST_IDLE;
              end
            end
            default: begin
              in_ready_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          endcase
        end
        ST_OUT_A: begin
          if (output_pc_ready) begin
            if (split_q) begin
              out_pc_q <= target_pc;
              state_q  <= ST_OUT_B;
            end else begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_OUT_B: begin
          if (output_pc_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          mem_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign input_pc_ready                   = in_ready_q;
  assign memory_valid                     = mem_valid_q;
  assign memory_addr                      = mem_addr_q;
  assign output_pc_valid                  = out_valid_q;
  assign output_pc                        = out_pc_q;
  assign output_cc_id                     = out_cc_q;
  assign output_pc_is_directed_to_current = out_dir_q;

endmodule

// File: tb/tb_basic_block_wide.sv
// tb/tb_basic_block_wide.sv - directed scoreboard bench for basic_block_wide.
module tb_basic_block_wide;
  import instruction::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_characters;
  logic        input_pc_valid;
  logic [7:0]  input_pc;
  logic [1:0]  input_cc_id;
  logic        input_pc_ready;
  logic        memory_valid;
  logic [10:0] memory_addr;
  logic        memory_ready;
  logic [15:0] memory_data;
  logic        output_pc_valid;
  logic [7:0]  output_pc;
  logic [1:0]  output_cc_id;
  logic        output_dir;
  logic        output_pc_ready;
  logic        accepts;

  basic_block_wide dut (
    .clk                              (clk),
    .reset                            (reset),
    .current_characters               (current_characters),
    .input_pc_valid                   (input_pc_valid),
    .input_pc                         (input_pc),
    .input_cc_id                      (input_cc_id),
    .input_pc_ready                   (input_pc_ready),
    .memory_valid                     (memory_valid),
    .memory_addr                      (memory_addr),
    .memory_ready                     (memory_ready),
    .memory_data                      (memory_data),
    .output_pc_valid                  (output_pc_valid),
    .output_pc                        (output_pc),
    .output_cc_id                     (output_cc_id),
    .output_pc_is_directed_to_current (output_dir),
    .output_pc_ready                  (output_pc_ready),
    .accepts                          (accepts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pc;
    logic [1:0] cc;
    logic       dir;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] mem [logic [10:0]];
  int          n_checks = 0;
  int          n_fails = 0;
  int          acc_seen = 0;
  int          out_seen = 0;
  int          fetch_count = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_pc;
  logic [1:0]  prev_cc;
  logic        prev_dir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [12:0] d);
    return {op, d};
  endfunction

  // Memory responder, acceptance counter and output scoreboard, all sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (memory_valid && memory_ready) begin
        memory_data = mem.exists(memory_addr) ? mem[memory_addr] : 16'hE000;
        fetch_count++;
      end
      if (accepts) acc_seen++;
      if (prev_stall) begin
        check("hold_valid", {31'd0, output_pc_valid}, 32'd1);
        check("hold_pc", {24'd0, output_pc}, {24'd0, prev_pc});
        check("hold_cc", {30'd0, output_cc_id}, {30'd0, prev_cc});
        check("hold_dir", {31'd0, output_dir}, {31'd0, prev_dir});
      end
      if (output_pc_valid && output_pc_ready) begin
        out_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", {24'd0, output_pc}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_pc", {24'd0, output_pc}, {24'd0, mon_e.pc});
          check("out_cc", {30'd0, output_cc_id}, {30'd0, mon_e.cc});
          check("out_dir", {31'd0, output_dir}, {31'd0, mon_e.dir});
        end
      end
      prev_stall = output_pc_valid && !output_pc_ready;
      prev_pc    = output_pc;
      prev_cc    = output_cc_id;
      prev_dir   = output_dir;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic intake(input logic [7:0] pc, input logic [1:0] cc);
    int n = 0;
    while (!input_pc_ready && n < 40) begin
      step();
      n++;
    end
    if (!input_pc_ready) check("intake_timeout", 32'd0, 32'd1);
    input_pc_valid = 1'b1;
    input_pc       = pc;
    input_cc_id    = cc;
    step();
    input_pc_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || !input_pc_ready) && n < 60) begin
      step();
      n++;
    end
    repeat (3) step();
    check(tag, exp_q.size(), 32'd0);
  endtask

  task automatic set_char(input int slot, input logic [7:0] val);
    current_characters[slot*8 +: 8] = val;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int a0;
    int o0;
    int f0;

    reset              = 1'b1;
    current_characters = '0;
    input_pc_valid     = 1'b0;
    input_pc           = '0;
    input_cc_id        = '0;
    memory_ready       = 1'b1;
    memory_data        = '0;
    output_pc_ready    = 1'b1;
    repeat (2) step();
    check("rst_mem_valid", {31'd0, memory_valid}, 32'd0);
    check("rst_mem_addr", {21'd0, memory_addr}, 32'd0);
    check("rst_out_valid", {31'd0, output_pc_valid}, 32'd0);
    check("rst_out_pc", {24'd0, output_pc}, 32'd0);
    check("rst_out_cc", {30'd0, output_cc_id}, 32'd0);
    check("rst_out_dir", {31'd0, output_dir}, 32'd0);
    check("rst_accepts", {31'd0, accepts}, 32'd0);
    reset = 1'b0;
    step();
    check("rst_in_ready", {31'd0, input_pc_ready}, 32'd1);

    // JMP, with intake-to-output latency
    mem[11'h0CC] = mk(JMP, 13'h00F);
    o0 = out_seen;
    exp_q.push_back({8'h0F, 2'd1, 1'b1});
    intake(8'hCC, 2'd1);
    check("fetch_addr", {21'd0, memory_addr}, 32'h0CC);
    lat = 1;
    while (!output_pc_valid && lat < 20) begin
      step();
      lat++;
    end
    check("latency", lat, 32'd4);
    drain("jmp_drain");
    check("jmp_count", out_seen - o0, 32'd1);

    // MATCH taken with cc wrap, then not taken
    set_char(3, 8'h61);
    mem[11'h010] = mk(MATCH, 13'h061);
    exp_q.push_back({8'h11, 2'd0, 1'b0});
    intake(8'h10, 2'd3);
    drain("match_drain");
    set_char(3, 8'h62);
    o0 = out_seen;
    intake(8'h10, 2'd3);
    drain("nomatch_drain");
    check("nomatch_count", out_seen - o0, 32'd0);

    // NOT_MATCH taken
    set_char(0, 8'h62);
    mem[11'h050] = mk(NOT_MATCH, 13'h061);
    exp_q.push_back({8'h51, 2'd1, 1'b0});
    intake(8'h50, 2'd0);
    drain("notmatch_drain");

    // SPLIT with backpressure
    output_pc_ready = 1'b0;
    mem[11'h020] = mk(SPLIT, 13'h040);
    exp_q.push_back({8'h21, 2'd2, 1'b1});
    exp_q.push_back({8'h40, 2'd2, 1'b1});
    intake(8'h20, 2'd2);
    lat = 0;
    while (!output_pc_valid && lat < 20) begin
      step();
      lat++;
    end
    check("split_first_pc", {24'd0, output_pc}, 32'h21);
    repeat (5) step();
    check("split_held_pc", {24'd0, output_pc}, 32'h21);
    check("split_held_valid", {31'd0, output_pc_valid}, 32'd1);
    output_pc_ready = 1'b1;
    drain("split_drain");

    // ACCEPT on zero / non-zero character, ACCEPT_PARTIAL, unused opcode
    mem[11'h030] = mk(ACCEPT, 13'h000);
    set_char(0, 8'h00);
    a0 = acc_seen;
    o0 = out_seen;
    intake(8'h30, 2'd0);
    drain("accept_drain");
    check("accept_pulse", acc_seen - a0, 32'd1);
    set_char(0, 8'h41);
    a0 = acc_seen;
    intake(8'h30, 2'd0);
    drain("noaccept_drain");
    check("noaccept_pulse", acc_seen - a0, 32'd0);
    mem[11'h060] = mk(ACCEPT_PARTIAL, 13'h000);
    a0 = acc_seen;
    intake(8'h60, 2'd0);
    drain("partial_drain");
    check("partial_pulse", acc_seen - a0, 32'd1);
    mem[11'h070] = mk(3'd7, 13'h005);
    a0 = acc_seen;
    intake(8'h70, 2'd0);
    drain("unused_drain");
    check("unused_pulse", acc_seen - a0, 32'd0);
    check("accept_no_output", out_seen - o0, 32'd0);

    // Reset while waiting for memory data
    mem[11'h080] = mk(JMP, 13'h011);
    a0 = acc_seen;
    o0 = out_seen;
    intake(8'h80, 2'd0);
    step();
    reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, output_pc_valid}, 32'd0);
    check("midrst_mem_valid", {31'd0, memory_valid}, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("midrst_in_ready", {31'd0, input_pc_ready}, 32'd1);
    repeat (8) step();
    check("midrst_no_output", out_seen - o0, 32'd0);
    check("midrst_no_accept", acc_seen - a0, 32'd0);

    // pc+1 wraps
    mem[11'h0FF] = mk(MATCH_ANY, 13'h000);
    exp_q.push_back({8'h00, 2'd3, 1'b0});
    intake(8'hFF, 2'd2);
    drain("wrap_drain");

    // Repeated pc: buffered build skips the second fetch
    mem[11'h090] = mk(JMP, 13'h033);
    exp_q.push_back({8'h33, 2'd1, 1'b1});
    intake(8'h90, 2'd1);
    drain("repeat1_drain");
    f0 = fetch_count;
    exp_q.push_back({8'h33, 2'd1, 1'b1});
    intake(8'h90, 2'd1);
    drain("repeat2_drain");
`ifdef BASIC_BLOCK_INSTR_CACHE_EN
    check("repeat_fetches", fetch_count - f0, 32'd0);
`else
    check("repeat_fetches", fetch_count - f0, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
